// File: rtl/prog_loader.sv
// Program loader: takes a byte stream over valid/ready, packs big-endian
// 32-bit words and writes them to instruction memory from address 0, then
// idles the memory port for one cycle and releases the processor.
module prog_loader #(
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 9
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              wr,
  output logic [31:0]       wdata,
  output logic              working,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_SETTLE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        b_q, b_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_q, wr_d;
  logic              working_q, working_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              xfer;

  // Place a byte at big-endian position idx (0 = most significant).
  function automatic logic [31:0] insert_byte(input logic [31:0] w,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  d);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[31:24] = d;
      2'd1:    r[23:16] = d;
      2'd2:    r[15:8]  = d;
      default: r[7:0]   = d;
    endcase
    return r;
  endfunction

  assign xfer = in_valid && in_ready_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    word_d  = word_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;

    if (start) begin
      // A start wins over any byte offered in the same cycle.
      state_d = S_LOAD;
      b_d     = 2'd0;
      word_d  = '0;
      last_d  = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (xfer) begin
            word_d = insert_byte(word_q, b_q, in_data);
            b_d    = b_q + 2'd1;
            if (b_q == 2'd3) begin
              state_d = S_WRITE;
              wdata_d = word_d;
              last_d  = in_last;
            end else if (in_last) begin
              // Program ended mid-word: nothing is written for it.
              state_d = S_ERROR;
              addr_d  = '0;
              wdata_d = '0;
            end
          end
        end
        S_WRITE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_q) begin
            state_d = S_SETTLE;
            addr_d  = '0;
            wdata_d = '0;
          end else if (cnt_d == CNT_W'(MAX_WORDS)) begin
            state_d = S_ERROR;
            addr_d  = '0;
            wdata_d = '0;
          end else begin
            state_d = S_LOAD;
            addr_d  = addr_q + ADDR_W'(1);
            b_d     = 2'd0;
          end
        end
        S_SETTLE: state_d = S_RUN;
        default:  ;
      endcase
    end

    in_ready_d = (state_d == S_LOAD);
    wr_d       = (state_d == S_WRITE);
    working_d  = (state_d == S_RUN);
    done_d     = (state_d == S_RUN);
    err_d      = (state_d == S_ERROR);
    busy_d     = (state_d == S_LOAD) || (state_d == S_WRITE) ||
                 (state_d == S_SETTLE);
  end

  // State and output registers; reset clears everything including the port.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      b_q        <= 2'd0;
      word_q     <= '0;
      last_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      wr_q       <= 1'b0;
      working_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      word_q     <= word_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      wr_q       <= wr_d;
      working_q  <= working_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign addr       = addr_q;
  assign wr         = wr_q;
  assign wdata      = wdata_q;
  assign working    = working_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: one default instance and one with
// MAX_WORDS=4 for the overflow case.
module tb_prog_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n, start, in_valid, in_last;
  logic [7:0]  in_data;
  logic        in_ready, wr, working, busy, done, err;
  logic [31:0] addr, wdata;
  logic [8:0]  word_count;

  logic        start4, in_valid4, in_last4;
  logic [7:0]  in_data4;
  logic        in_ready4, wr4, working4, busy4, done4, err4;
  logic [31:0] addr4, wdata4;
  logic [8:0]  word_count4;

  prog_loader u_dut (
    .clock(clock), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .addr(addr),
    .wr(wr), .wdata(wdata), .working(working), .busy(busy), .done(done),
    .err(err), .word_count(word_count)
  );

  prog_loader #(.ADDR_W(32), .MAX_WORDS(4), .CNT_W(9)) u_dut4 (
    .clock(clock), .rst_n(rst_n), .start(start4), .in_valid(in_valid4),
    .in_data(in_data4), .in_last(in_last4), .in_ready(in_ready4),
    .addr(addr4), .wr(wr4), .wdata(wdata4), .working(working4),
    .busy(busy4), .done(done4), .err(err4), .word_count(word_count4)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  prog  [0:19] = '{8'h10, 8'hf0, 8'h00, 8'h10, 8'h20, 8'h01, 8'h00,
                                8'h00, 8'h21, 8'h23, 8'h00, 8'h00, 8'h22, 8'h45,
                                8'h00, 8'h00, 8'h23, 8'h67, 8'h00, 8'h00};
  logic [31:0] exp_w [0:4]  = '{32'h10f00010, 32'h20010000, 32'h21230000,
                                32'h22450000, 32'h23670000};

  // Write-port loggers for both instances.
  logic [31:0] log_addr [0:63];
  logic [31:0] log_data [0:63];
  int          log_n = 0;
  int          dbl = 0;
  logic        wr_prev = 1'b0;
  logic [31:0] log4_addr [0:15];
  logic [31:0] log4_data [0:15];
  int          log4_n = 0;

  always @(negedge clock) begin
    wr_prev <= wr;
    if (wr === 1'b1 && wr_prev === 1'b1) dbl <= dbl + 1;
    if (wr === 1'b1 && log_n < 64) begin
      log_addr[log_n] <= addr;
      log_data[log_n] <= wdata;
      log_n <= log_n + 1;
    end
  end

  always @(negedge clock) begin
    if (wr4 === 1'b1 && log4_n < 16) begin
      log4_addr[log4_n] <= addr4;
      log4_data[log4_n] <= wdata4;
      log4_n <= log4_n + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic pulse_start4();
    start4 = 1'b1;
    @(posedge clock); #1;
    start4 = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clock);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("send_handshake_timeout", 96'(n >= 50), 96'(0));
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send4(input logic [7:0] d);
    int n;
    n = 0;
    in_valid4 = 1'b1; in_data4 = d; in_last4 = 1'b0;
    @(negedge clock);
    while (in_ready4 !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("send4_handshake_timeout", 96'(n >= 50), 96'(0));
    @(posedge clock); #1;
    in_valid4 = 1'b0;
  endtask

  // Called just after the final byte's edge: WRITE, SETTLE, then RUN.
  task automatic check_program(input string tag, input int base);
    @(negedge clock);
    chk({tag, "_last_wr"}, {63'(addr), wr}, {63'd4, 1'b1});
    @(negedge clock);
    chk({tag, "_settle_port"}, {32'd0, addr, wdata, wr}, 96'd0);
    chk({tag, "_settle_busy_working"}, {94'd0, busy, working}, {94'd0, 2'b10});
    @(negedge clock);
    chk({tag, "_run_flags"}, {92'd0, working, done, busy, in_ready},
        {92'd0, 4'b1100});
    chk({tag, "_word_count"}, 96'(word_count), 96'd5);
    chk({tag, "_wr_pulses"}, 96'(log_n - base), 96'd5);
    for (int i = 0; i < 5; i++) begin
      chk({tag, "_write_entry"}, {32'd0, log_addr[base + i], log_data[base + i]},
          {32'd0, 32'(i), exp_w[i]});
    end
  endtask

  initial begin
    int   base;
    int   base4;
    logic acc17;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    start4 = 1'b0; in_valid4 = 1'b0; in_data4 = 8'h00; in_last4 = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", 96'({addr, wr, wdata, working, in_ready, busy, done, err, word_count}), 96'd0);
    chk("reset_outputs4", 96'({addr4, wr4, wdata4, working4, in_ready4, busy4, done4, err4, word_count4}), 96'd0);
    @(posedge clock); #1;
    rst_n = 1'b1;

    // Continuous 5-word program.
    pulse_start();
    @(negedge clock);
    chk("start_load_flags", {93'd0, in_ready, busy, working}, {93'd0, 3'b110});
    @(posedge clock); #1;
    base = log_n;
    for (int i = 0; i < 20; i++) send(prog[i], i == 19);
    check_program("stream", base);

    // Start from RUN, then the same program with source stalls.
    pulse_start();
    @(negedge clock);
    chk("run_restart", {92'd0, working, in_ready, done, busy}, {92'd0, 4'b0101});
    chk("run_restart_count", 96'(word_count), 96'd0);
    @(posedge clock); #1;
    base = log_n;
    for (int i = 0; i < 20; i++) begin
      send(prog[i], i == 19);
      if (i % 2 == 1 && i < 19) begin
        repeat (3) @(posedge clock);
        #1;
      end
    end
    check_program("stalled", base);

    // Partial trailing word.
    pulse_start();
    base = log_n;
    for (int i = 0; i < 6; i++) send(prog[i], i == 5);
    @(negedge clock);
    chk("partial_err_flags", {92'd0, err, working, wr, in_ready}, {92'd0, 4'b1000});
    chk("partial_word_count", 96'(word_count), 96'd1);
    chk("partial_one_write", {32'd0, 32'(log_n - base), log_addr[base]}, {32'd0, 32'd1, 32'd0});
    chk("partial_wdata", 96'(log_data[base]), 96'(32'h10f00010));

    // Overflow on the MAX_WORDS=4 instance.
    @(posedge clock); #1;
    pulse_start4();
    base4 = log4_n;
    for (int i = 0; i < 16; i++) send4(8'(i));
    in_valid4 = 1'b1; in_data4 = 8'd16;
    acc17 = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (in_ready4 === 1'b1) acc17 = 1'b1;
    end
    in_valid4 = 1'b0;
    chk("ovf_17th_refused", 96'(acc17), 96'd0);
    chk("ovf_flags", {93'd0, err4, in_ready4, working4}, {93'd0, 3'b100});
    chk("ovf_word_count", 96'(word_count4), 96'd4);
    chk("ovf_wr_pulses", 96'(log4_n - base4), 96'd4);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_write_entry", {32'd0, log4_addr[base4 + i], log4_data[base4 + i]},
          {32'd0, 32'(i), 8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)});
    end

    // Reset mid-load, then a one-word program.
    @(posedge clock); #1;
    pulse_start();
    base = log_n;
    for (int i = 0; i < 8; i++) send(prog[i], 1'b0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("midload_count", 96'(word_count), 96'd2);
    chk("midload_pulses", 96'(log_n - base), 96'd2);
    @(posedge clock); #1;
    rst_n = 1'b0;
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(negedge clock);
    chk("midload_reset_outputs", 96'({addr, wr, wdata, working, in_ready, busy, done, err, word_count}), 96'd0);
    pulse_start();
    send(8'hde, 1'b0); send(8'had, 1'b0); send(8'hbe, 1'b0); send(8'hef, 1'b1);
    @(negedge clock);
    chk("one_word_write", {31'd0, wr, addr, wdata}, {31'd0, 1'b1, 32'd0, 32'hdeadbeef});
    @(negedge clock);
    @(negedge clock);
    chk("one_word_run", {85'd0, working, done, word_count}, {85'd0, 1'b1, 1'b1, 9'd1});

    // Restart from RUN; a start colliding with a byte discards it.
    pulse_start();
    @(negedge clock);
    chk("restart_load", {93'd0, working, in_ready, busy}, {93'd0, 3'b011});
    @(posedge clock); #1;
    base = log_n;
    send(8'h11, 1'b0); send(8'h22, 1'b0);
    start = 1'b1; in_valid = 1'b1; in_data = 8'h33;
    @(posedge clock); #1;
    start = 1'b0; in_valid = 1'b0;
    in_last = 1'b1;
    @(posedge clock); #1;
    in_last = 1'b0;
    send(8'h44, 1'b0); send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b1);
    @(negedge clock);
    chk("collide_write", {31'd0, wr, addr, wdata}, {31'd0, 1'b1, 32'd0, 32'h44556677});
    @(negedge clock);
    @(negedge clock);
    chk("collide_run", {85'd0, working, err, word_count}, {85'd0, 1'b1, 1'b0, 9'd1});
    chk("collide_pulses", 96'(log_n - base), 96'd1);

    chk("no_back_to_back_wr", 96'(dbl), 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
